// File: rtl/bignum_add_arbiter.sv
// Round-robin arbiter feeding a chunk-serial bignum adder: the owner streams operand A then B,
// and the adder's sum chunks are forwarded back tagged with the owner. Option: ARB_OP_COUNT_EN.
module bignum_add_arbiter #(
  parameter int unsigned register_size = 32,
  parameter int unsigned bits_in_num   = 2048,
  parameter int unsigned NUM_REQ       = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [NUM_REQ-1:0]                 req_in,
  input  logic [NUM_REQ*register_size-1:0]   chunk_in,
  input  logic [NUM_REQ-1:0]                 valid_in,
  output logic [NUM_REQ-1:0]                 grant_out,
  output logic                               busy_out,
  output logic [register_size-1:0]           adder_chunk_out,
  output logic                               adder_valid_out,
  input  logic [register_size-1:0]           adder_data_in,
  input  logic                               adder_valid_in,
  input  logic                               adder_carry_in,
  input  logic                               adder_final_in,
  output logic [register_size-1:0]           res_data_out,
  output logic                               res_valid_out,
  output logic                               res_carry_out,
  output logic                               res_final_out,
  output logic [$clog2(NUM_REQ)-1:0]         res_id_out,
  output logic [15:0]                        ops_count_out
);

  localparam int unsigned CHUNKS = bits_in_num / register_size;
  localparam int unsigned IW     = $clog2(NUM_REQ);
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, FEED_A, FEED_B, DRAIN} state_t;

  state_t               r_state;
  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_last;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        w_winner;
  logic                 w_found;
  int unsigned          w_idx;
  logic                 w_own_valid;
  logic                 w_feeding;

  // Reset asserts asynchronously, releases two clocks after rst_n_in rises
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Round-robin search starting one past the last winner
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_last) + k) % NUM_REQ;
      if (!w_found && req_in[IW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  assign w_feeding       = (r_state == FEED_A) || (r_state == FEED_B);
  assign w_own_valid     = valid_in[r_owner];
  assign adder_valid_out = w_feeding && w_own_valid;
  assign adder_chunk_out = w_feeding ? chunk_in[r_owner*register_size +: register_size]
                                     : '0;
  assign grant_out       = r_grant;
  assign busy_out        = r_busy;
  assign res_id_out      = r_owner;

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_owner       <= '0;
      r_last        <= IW'(NUM_REQ - 1);
      r_cnt         <= '0;
      res_data_out  <= '0;
      res_valid_out <= 1'b0;
      res_carry_out <= 1'b0;
      res_final_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          res_data_out  <= '0;
          res_valid_out <= 1'b0;
          res_carry_out <= 1'b0;
          res_final_out <= 1'b0;
          if (w_found) begin
            r_grant <= NUM_REQ'(1) << w_winner;
            r_busy  <= 1'b1;
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_state <= FEED_A;
          end
        end
        FEED_A, FEED_B: begin
          res_data_out  <= adder_data_in;
          res_valid_out <= adder_valid_in;
          res_carry_out <= 1'b0;
          res_final_out <= 1'b0;
          if (w_own_valid) begin
            if (r_cnt == CW'(CHUNKS - 1)) begin
              r_cnt   <= '0;
              r_state <= (r_state == FEED_A) ? FEED_B : DRAIN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          res_data_out  <= adder_data_in;
          res_valid_out <= adder_valid_in;
          res_carry_out <= adder_carry_in & adder_final_in;
          res_final_out <= adder_final_in;
          if (adder_final_in) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_OP_COUNT_EN
  logic [15:0] r_ops;

  // Completed operations, wrapping at 16 bits
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)                                  r_ops <= '0;
    else if (r_state == DRAIN && adder_final_in)   r_ops <= r_ops + 16'd1;
  end
  assign ops_count_out = r_ops;
`else
  assign ops_count_out = 16'h0000;
`endif

endmodule

// File: doc/bignum_add_arbiter.md
BIGNUM_ADD_ARBITER -- requirements
Module: bignum_add_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- register_size, 32, chunk width.
- bits_in_num, 2048, operand width.
- NUM_REQ, 2, requester count, at least 2.
- CHUNKS = bits_in_num/register_size, derived.
REQ-002 Ports SHALL be:
- clk_in, in, 1, sole clock.
- rst_n_in, in, 1, asynchronous active-low reset.
- req_in, in, NUM_REQ, per-requester request level.
- chunk_in, in, NUM_REQ*register_size, packed requester chunks; requester i occupies slice i.
- valid_in, in, NUM_REQ, per-requester chunk valid.
- grant_out, out, NUM_REQ, one-hot owner.
- busy_out, out, 1, a transaction is in progress.
- adder_chunk_out, out, register_size, chunk to the chunk-serial adder.
- adder_valid_out, out, 1, adder chunk valid.
- adder_data_in, in, register_size, adder sum chunk.
- adder_valid_in, in, 1, adder sum valid.
- adder_carry_in, in, 1, adder final carry.
- adder_final_in, in, 1, last sum chunk.
- res_data_out, out, register_size, forwarded sum chunk.
- res_valid_out, out, 1, forwarded sum valid.
- res_carry_out, out, 1, final carry, valid with res_final_out.
- res_final_out, out, 1, last result chunk.
- res_id_out, out, $clog2(NUM_REQ), owner of the result.
- ops_count_out, out, 16, completed-operation count.

Function
REQ-003 The FSM SHALL have four states: IDLE, FEED_A, FEED_B, DRAIN.
REQ-004 In IDLE with any req_in bit high, the block SHALL select one requester by round-robin, starting at (last winner + 1) mod NUM_REQ. On the next edge it SHALL assert that requester's grant_out bit and enter FEED_A.
REQ-005 grant_out and busy_out SHALL remain asserted from FEED_A through DRAIN, even if the owner drops req_in.
REQ-006 In FEED_A and FEED_B, adder_chunk_out and adder_valid_out SHALL combinationally equal the owner's chunk_in slice and valid_in bit. In all other states adder_valid_out SHALL be 0.
REQ-007 valid_in from non-owners SHALL be ignored in every state.
REQ-008 A chunk counter SHALL advance only on owner valid cycles.
REQ-009 FEED_A SHALL move to FEED_B on the CHUNKS-th valid chunk; FEED_B SHALL move to DRAIN on the CHUNKS-th valid chunk. Gaps in valid_in SHALL be tolerated.
REQ-010 In any non-IDLE state, res_data_out, res_valid_out, res_carry_out and res_final_out SHALL be the adder_* inputs registered one cycle. res_id_out SHALL be the owner index.
REQ-011 res_carry_out SHALL be 0 except in the cycle res_final_out is 1.
REQ-012 adder_final_in SHALL cause a transition to IDLE. It SHALL deassert grant_out and busy_out on the next edge and update the last-winner pointer. The next grant SHALL come no earlier than the following cycle (one-cycle bubble).
REQ-013 An adder_final_in received outside DRAIN SHALL be ignored.

Reset
REQ-014 Assertion of rst_n_in SHALL immediately force the following, in any state including mid-operation:
- state to IDLE;
- counters and grant_out to 0;
- last-winner pointer to NUM_REQ-1, so requester 0 wins first;
- all outputs to 0.
REQ-015 Deassertion of rst_n_in SHALL be synchronized to clk_in internally.

Configuration
REQ-016 With macro ARB_OP_COUNT_EN defined, ops_count_out SHALL increment by 1 on each accepted adder_final_in, wrap from 0xFFFF to 0, and reset to 0.
REQ-017 Without ARB_OP_COUNT_EN, ops_count_out SHALL be constant 0 and the counter logic SHALL be absent.

Verification
Bench settings: register_size=32, bits_in_num=128 (CHUNKS=4), NUM_REQ=2, driving a behavioural chunk-serial adder.
REQ-018 Single add: req0 sends A = four chunks of 0xFFFFFFFF, then B = {1,0,0,0} -> four res_data_out = 0x00000000, res_carry_out=1 with res_final_out, res_id_out=0.
REQ-019 Round-robin: req_in=2'b11 held after reset -> grants go 0,1,0; each grant is separated by one idle cycle after res_final_out.
REQ-020 Gapped stream: owner valid_in toggles 1,0,0,1,... -> exactly 8 adder_valid_out pulses, FEED_B to DRAIN on the 8th, sum correct.
REQ-021 Intruder: req1 drives valid_in=1, chunk 0xDEADBEEF while req0 owns -> adder_chunk_out never equals the intruder's data, req0 result correct.
REQ-022 Reset mid-FEED_B (after 2 B chunks): rst_n_in low -> same cycle grant_out=0, busy_out=0, res_valid_out=0; after release, req1 alone is granted cleanly.
REQ-023 Three back-to-back ops -> ops_count_out=3 with ARB_OP_COUNT_EN defined, 0 without.
